// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier: classify/unpack, mantissa product, normalise/round/pack.
// A single advance signal moves every stage together; a tag rides alongside each operand pair.
module fp_mul_pipe #(
  parameter int EXP_W       = 8,
  parameter int MAN_W       = 23,
  parameter int PIPE_STAGES = 3,
  parameter int TAG_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in1,
  input  logic [EXP_W+MAN_W:0] in2,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           out_flags
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * MAN_W + 2;
  localparam int LZ_W   = $clog2(PROD_W);
  localparam int XW     = EXP_W + LZ_W + 2;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 2);
  localparam logic signed [XW-1:0] EXP_MIN = XW'(1);

  typedef struct packed {
    logic             sign;
    logic [EXP_W+1:0] exp;
    logic             special;
    logic [W-1:0]     sp_val;
    logic [3:0]       sp_flags;
    logic [TAG_W-1:0] tag;
  } ctl_t;

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  assign {sa, ea, ma} = in1;
  assign {sb, eb, mb} = in2;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign a_nan  = (&ea) & (|ma);
  assign b_nan  = (&eb) & (|mb);
  assign a_inf  = (&ea) & ~(|ma);
  assign b_inf  = (&eb) & ~(|mb);
  assign a_zero = ~(|ea) & ~(|ma);
  assign b_zero = ~(|eb) & ~(|mb);

  ctl_t             s1_d, s1_q;
  logic [SIG_W-1:0] sig_a_q, sig_b_q;
  logic             s1_v;

  // NOTE: every field gets a default before the priority chain, so no path can infer a latch.
  always_comb begin
    s1_d          = '0;
    s1_d.sign     = sa ^ sb;
    s1_d.tag      = in_tag;
    s1_d.exp      = {2'b00, (ea == '0) ? EXP_W'(1) : ea}
                  + {2'b00, (eb == '0) ? EXP_W'(1) : eb} - (EXP_W+2)'(BIAS);
    s1_d.special  = 1'b1;
    if (b_nan) begin
      s1_d.sp_val   = {sb, {EXP_W{1'b1}}, 1'b1, mb[MAN_W-2:0]};
      s1_d.sp_flags = {~mb[MAN_W-1], 3'b000};
    end else if (a_nan) begin
      s1_d.sp_val   = {sa, {EXP_W{1'b1}}, 1'b1, ma[MAN_W-2:0]};
      s1_d.sp_flags = {~ma[MAN_W-1], 3'b000};
    end else if ((a_inf & b_zero) | (a_zero & b_inf)) begin
      s1_d.sp_val   = {s1_d.sign, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      s1_d.sp_flags = 4'b1000;
    end else if (a_inf | b_inf) begin
      s1_d.sp_val   = {s1_d.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero | b_zero) begin
      s1_d.sp_val   = {s1_d.sign, {(W-1){1'b0}}};
    end else begin
      s1_d.special  = 1'b0;
    end
  end

  // NOTE: only valid bits are reset; datapath registers are qualified by them and need no reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     s1_v <= 1'b0;
    else if (advance) s1_v <= in_valid;
  end

  // NOTE: nonblocking assignments let every stage capture its pre-edge input in the same step.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_q    <= s1_d;
      sig_a_q <= {|ea, ma};
      sig_b_q <= {|eb, mb};
    end
  end

  logic [PROD_W-1:0] prod_d, s3_prod;
  ctl_t              s3_ctl;
  logic              s3_v;
  assign prod_d = PROD_W'(sig_a_q) * PROD_W'(sig_b_q);

  // Stages beyond two sit behind the multiplier so synthesis can retime it across them.
  generate
    if (PIPE_STAGES > 2) begin : g_mid
      localparam int D = PIPE_STAGES - 2;
      ctl_t              ctl_q  [D];
      logic [PROD_W-1:0] prod_q [D];
      logic [D-1:0]      v_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) v_q <= '0;
        else if (advance) begin
          v_q[0] <= s1_v;
          for (int i = 1; i < D; i++) v_q[i] <= v_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          ctl_q[0]  <= s1_q;
          prod_q[0] <= prod_d;
          for (int i = 1; i < D; i++) begin
            ctl_q[i]  <= ctl_q[i-1];
            prod_q[i] <= prod_q[i-1];
          end
        end
      end

      assign s3_ctl  = ctl_q[D-1];
      assign s3_prod = prod_q[D-1];
      assign s3_v    = v_q[D-1];
    end else begin : g_merge
      assign s3_ctl  = s1_q;
      assign s3_prod = prod_d;
      assign s3_v    = s1_v;
    end
  endgenerate

  logic [LZ_W-1:0]        lead;
  logic [PROD_W-1:0]      norm;
  logic                   guard, rnd, sticky, round_up, inexact;
  logic [MAN_W:0]         frac_r;
  logic signed [XW-1:0]   exp_r;
  logic [W-1:0]           res;
  logic [3:0]             flags;

  always_comb begin
    lead = '0;
    for (int i = 0; i < PROD_W; i++) if (s3_prod[i]) lead = LZ_W'(i);
    norm     = s3_prod << (LZ_W'(PROD_W - 1) - lead);
    guard    = norm[PROD_W-1-SIG_W];
    rnd      = norm[PROD_W-2-SIG_W];
    sticky   = |norm[PROD_W-3-SIG_W:0];
    round_up = guard & (rnd | sticky | norm[PROD_W-SIG_W]);
    inexact  = guard | rnd | sticky;
    // The hidden bit is always 1 after normalising, so a carry out of the fraction means 2.0.
    frac_r   = {1'b0, norm[PROD_W-2 -: MAN_W]} + (MAN_W+1)'(round_up);
    exp_r    = {{(XW-EXP_W-2){s3_ctl.exp[EXP_W+1]}}, s3_ctl.exp} + XW'(lead)
             - XW'(PROD_W - 2) + XW'(frac_r[MAN_W]);
    res      = '0;
    flags    = '0;
    if (s3_ctl.special) begin
      res   = s3_ctl.sp_val;
      flags = s3_ctl.sp_flags;
    end else if (exp_r > EXP_MAX) begin
      res   = {s3_ctl.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags = 4'b0101;
    end else if (exp_r < EXP_MIN) begin
      res   = {s3_ctl.sign, {(W-1){1'b0}}};
      flags = {3'b001, norm[PROD_W-1]};
    end else begin
      res   = {s3_ctl.sign, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
      flags = {3'b000, inexact};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else if (advance) begin
      out_valid <= s3_v;
      out       <= res;
      out_tag   <= s3_ctl.tag;
      out_flags <= flags;
    end
  end
endmodule
